// File: rtl/led_matrix_scan_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_matrix_scan_multi_if
//  Brief    : Control, bitmap-write and matrix-pin bundle for
//             led_matrix_scan_multi. The display controller drives it through
//             the master modport, and the scan driver uses the slave modport.
//  Revision : 1.0  initial release
// ============================================================================
interface led_matrix_scan_multi_if #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int NGLYPH = 4
);
  // A single glyph still needs a one-bit select so that the port exists.
  localparam int c_glyph_w = (NGLYPH > 1) ? $clog2(NGLYPH) : 1;
  localparam int c_row_w   = $clog2(ROWS);

  logic                 en;
  logic [c_glyph_w-1:0] glyph_sel;
  logic                 wr_en;
  logic [c_glyph_w-1:0] wr_glyph;
  logic [c_row_w-1:0]   wr_row;
  logic [COLS-1:0]      wr_data;
  logic                 blink;
  logic [ROWS-1:0]      line;
  logic [COLS-1:0]      row;
  logic                 frame_done;

  modport master (
    output en, glyph_sel, wr_en, wr_glyph, wr_row, wr_data, blink,
    input  line, row, frame_done
  );

  modport slave (
    input  en, glyph_sel, wr_en, wr_glyph, wr_row, wr_data, blink,
    output line, row, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/led_matrix_scan_multi.sv
`default_nettype none
// ============================================================================
//  Module   : led_matrix_scan_multi
//  Brief    : Row-scan driver for an LED dot matrix with NGLYPH writable
//             bitmaps. It drives one row at a time with a programmable dwell
//             and switches glyphs only at frame boundaries.
//             Optional feature macro: BLINK_EN. When BLINK_EN is defined, the
//             module blanks the column data on alternate groups of
//             BLINK_FRAMES frames while blink is high.
//  Revision : 1.0  initial release
// ============================================================================
module led_matrix_scan_multi #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int NGLYPH       = 4,
  parameter int DWELL        = 1,
  parameter int BLINK_FRAMES = 64
) (
  input  wire                      fs,
  input  wire                      rst,
  led_matrix_scan_multi_if.slave   bus
);

  localparam int c_glyph_w = (NGLYPH > 1) ? $clog2(NGLYPH) : 1;
  localparam int c_idx_w   = $clog2(ROWS);
  localparam int c_cnt_w   = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(ROWS - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DWELL - 1);

  // Scan state
  logic [c_idx_w-1:0]   idx_q,  idx_d;
  logic [c_cnt_w-1:0]   cnt_q,  cnt_d;
  logic [c_glyph_w-1:0] act_q,  act_d;
  logic [ROWS-1:0]      line_q, line_d;
  logic [COLS-1:0]      row_q,  row_d;
  logic                 fd_q,   fd_d;

  // Bitmap store
  logic [COLS-1:0] mem_q [NGLYPH][ROWS];
  logic [COLS-1:0] mem_d [NGLYPH][ROWS];

  logic w_sel_ok;
  logic w_wr_ok;
  logic w_dwell_end;
  logic w_last_row;
  logic w_wrap;
  logic w_blank;

  // An out-of-range select or write target is ignored instead of aliased.
  assign w_sel_ok    = (int'(bus.glyph_sel) < NGLYPH);
  assign w_wr_ok     = bus.wr_en && (int'(bus.wr_glyph) < NGLYPH)
                                 && (int'(bus.wr_row) < ROWS);
  assign w_dwell_end = (cnt_q == c_cnt_last);
  assign w_last_row  = (idx_q == c_idx_last);
  assign w_wrap      = bus.en && w_dwell_end && w_last_row;

`ifdef BLINK_EN
  localparam int c_bf_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_bf_w-1:0] c_bf_last = c_bf_w'(BLINK_FRAMES - 1);

  logic [c_bf_w-1:0] bcnt_q,  bcnt_d;
  logic              phase_q, phase_d;

  // Frame counter and blink phase. Both are held at zero while blink is low.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (!bus.blink) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (w_wrap) begin
      if (bcnt_q == c_bf_last) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // Blink state register
  always_ff @(posedge fs or posedge rst) begin
    if (rst) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign w_blank = bus.blink && phase_q;
`else
  // Blink has no effect in this build. The port and parameter stay in place so
  // that instantiations do not change.
  logic w_unused_blink;
  assign w_unused_blink = bus.blink & (BLINK_FRAMES > 0);
  assign w_blank        = 1'b0;
`endif

  // Next scan position and registered row and line outputs. These read the
  // bitmap before this cycle's write, so a same-cycle write shows up one cycle
  // later.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    line_d = '0;
    row_d  = '0;
    fd_d   = 1'b0;
    if (!bus.en) begin
      idx_d = '0;
      cnt_d = '0;
      if (w_sel_ok) begin
        act_d = bus.glyph_sel;
      end
    end else begin
      line_d[idx_q] = 1'b1;
      row_d         = w_blank ? '0 : mem_q[act_q][idx_q];
      if (w_dwell_end) begin
        cnt_d = '0;
        if (w_last_row) begin
          idx_d = '0;
          fd_d  = 1'b1;
          if (w_sel_ok) begin
            act_d = bus.glyph_sel;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Scan state and output register
  always_ff @(posedge fs or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      act_q  <= '0;
      line_q <= '0;
      row_q  <= '0;
      fd_q   <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      line_q <= line_d;
      row_q  <= row_d;
      fd_q   <= fd_d;
    end
  end

  // Bitmap write port. Writes are accepted whether or not the scan is enabled.
  always_comb begin
    mem_d = mem_q;
    if (w_wr_ok) begin
      mem_d[bus.wr_glyph][bus.wr_row] = bus.wr_data;
    end
  end

  // Bitmap storage, cleared by reset
  always_ff @(posedge fs or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < NGLYPH; g++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem_q[g][r] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign bus.line       = line_q;
  assign bus.row        = row_q;
  assign bus.frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scan_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_matrix_scan_multi
//  Brief    : Self-checking bench for led_matrix_scan_multi. Instance A is an
//             8x8 matrix with 3 glyphs and dwell 1. Instance B has 5 rows,
//             4 columns, 2 glyphs and dwell 3.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_led_matrix_scan_multi;

  localparam int RA = 8, CA = 8, GA = 3, DA = 1, BFA = 2;
  localparam int RB = 5, CB = 4, GB = 2, DB = 3;

  logic fs  = 1'b0;
  logic rst = 1'b1;
  always #5 fs = ~fs;

  led_matrix_scan_multi_if #(.ROWS(RA), .COLS(CA), .NGLYPH(GA)) bus_a ();
  led_matrix_scan_multi_if #(.ROWS(RB), .COLS(CB), .NGLYPH(GB)) bus_b ();

  led_matrix_scan_multi #(.ROWS(RA), .COLS(CA), .NGLYPH(GA), .DWELL(DA),
                          .BLINK_FRAMES(BFA))
    dut_a (.fs(fs), .rst(rst), .bus(bus_a.slave));

  led_matrix_scan_multi #(.ROWS(RB), .COLS(CB), .NGLYPH(GB), .DWELL(DB),
                          .BLINK_FRAMES(2))
    dut_b (.fs(fs), .rst(rst), .bus(bus_b.slave));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model for instance A. Scan position is a plain cycle count
  // within the frame.
  logic [CA-1:0] m_mem [GA][RA];
  int            m_act, m_pos, m_fc;
  logic [RA-1:0] e_line;
  logic [CA-1:0] e_row;
  logic          e_fd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < GA; g++)
      for (int r = 0; r < RA; r++) m_mem[g][r] = '0;
    m_act = 0; m_pos = 0; m_fc = 0;
    e_line = '0; e_row = '0; e_fd = 1'b0;
  endtask

  // Advance the model by one clock edge, using the inputs as they are now.
  task automatic model_edge();
    int r;
    bit last;
    last = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (!bus_a.en) begin
      e_line = '0; e_row = '0; e_fd = 1'b0; m_pos = 0;
      if (int'(bus_a.glyph_sel) < GA) m_act = int'(bus_a.glyph_sel);
    end else begin
      r      = (m_pos / DA) % RA;
      e_line = RA'(1) << r;
      e_row  = m_mem[m_act][r];
`ifdef BLINK_EN
      if (bus_a.blink && ((m_fc / BFA) % 2 == 1)) e_row = '0;
`endif
      last  = (m_pos == RA * DA - 1);
      e_fd  = last;
      m_pos = (m_pos + 1) % (RA * DA);
      if (last && int'(bus_a.glyph_sel) < GA) m_act = int'(bus_a.glyph_sel);
    end
    if (!bus_a.blink) m_fc = 0;
    else if (last)    m_fc = (m_fc + 1) % (2 * BFA);
    if (bus_a.wr_en && int'(bus_a.wr_glyph) < GA && int'(bus_a.wr_row) < RA)
      m_mem[bus_a.wr_glyph][bus_a.wr_row] = bus_a.wr_data;
  endtask

  task automatic step(input bit use_model);
    model_edge();
    @(posedge fs); #1;
    if (use_model) begin
      chk("line", 32'(bus_a.line), 32'(e_line));
      chk("row", 32'(bus_a.row), 32'(e_row));
      chk("frame_done", 32'(bus_a.frame_done), 32'(e_fd));
    end
  endtask

  task automatic wr_a(input int g, input int r, input logic [CA-1:0] d);
    bus_a.wr_en = 1'b1; bus_a.wr_glyph = 2'(g); bus_a.wr_row = 3'(r); bus_a.wr_data = d;
    step(1);
    bus_a.wr_en = 1'b0;
  endtask

  typedef struct {
    bit            en;
    bit            we;
    logic [1:0]    wg;
    logic [2:0]    wrow;
    logic [CA-1:0] wd;
    logic [RA-1:0] xl;
    logic [CA-1:0] xr;
    bit            xf;
  } vec_t;

  vec_t          tv [20];
  logic [CA-1:0] pat [8];

  initial begin
    pat = '{8'h81, 8'h7E, 8'h4A, 8'h3E, 8'h3E, 8'h4A, 8'h7E, 8'h81};
    // Rows 0..7: load glyph 0 with scanning off. Rows 8..16: scan the first
    // frame. Row 16 also rewrites row 0, and the old data shows that cycle.
    // Rows 17..19 then show row 1, blank on en low, and restart at row 0
    // with the new data.
    for (int i = 0; i < 8; i++)
      tv[i] = '{1'b0, 1'b1, 2'd0, 3'(i), pat[i], '0, '0, 1'b0};
    for (int k = 0; k < 9; k++)
      tv[8+k] = '{1'b1, 1'b0, 2'd0, 3'd0, 8'h00, RA'(1) << (k % 8), pat[k % 8], (k == 7)};
    tv[16].we = 1'b1; tv[16].wrow = 3'd0; tv[16].wd = 8'h55;
    tv[17] = '{1'b1, 1'b0, 2'd0, 3'd0, 8'h00, 8'h02, 8'h7E, 1'b0};
    tv[18] = '{1'b0, 1'b0, 2'd0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0};
    tv[19] = '{1'b1, 1'b0, 2'd0, 3'd0, 8'h00, 8'h01, 8'h55, 1'b0};

    {bus_a.en, bus_a.glyph_sel, bus_a.wr_en, bus_a.wr_glyph, bus_a.wr_row,
     bus_a.wr_data, bus_a.blink} = '0;
    {bus_b.en, bus_b.glyph_sel, bus_b.wr_en, bus_b.wr_glyph, bus_b.wr_row,
     bus_b.wr_data, bus_b.blink} = '0;
    model_reset();

    // Reset state
    rst = 1'b1;
    step(0); step(0);
    chk("reset_line", 32'(bus_a.line), 32'h0);
    chk("reset_row", 32'(bus_a.row), 32'h0);
    chk("reset_fd", 32'(bus_a.frame_done), 32'h0);
    rst = 1'b0;

    // Zero bitmap: walking line, row 0, and one frame_done per 8 cycles
    bus_a.en = 1'b1;
    for (int i = 0; i < 17; i++) step(1);
    bus_a.en = 1'b0;
    step(1);

    // Table vectors
    for (int i = 0; i < 20; i++) begin
      bus_a.en = tv[i].en; bus_a.wr_en = tv[i].we; bus_a.wr_glyph = tv[i].wg;
      bus_a.wr_row = tv[i].wrow; bus_a.wr_data = tv[i].wd;
      step(0);
      chk($sformatf("tv%0d_line", i), 32'(bus_a.line), 32'(tv[i].xl));
      chk($sformatf("tv%0d_row", i), 32'(bus_a.row), 32'(tv[i].xr));
      chk($sformatf("tv%0d_fd", i), 32'(bus_a.frame_done), 32'(tv[i].xf));
    end
    bus_a.wr_en = 1'b0;

    // Glyph switch mid-frame, an invalid write target, and an invalid select
    bus_a.en = 1'b0;
    for (int r = 0; r < RA; r++) wr_a(1, r, 8'h10 + 8'(r));
    for (int r = 0; r < RA; r++) wr_a(2, r, 8'hA0 + 8'(r));
    wr_a(3, 0, 8'hFF);
    wr_a(3, 5, 8'hEE);
    bus_a.glyph_sel = 2'd0;
    step(1);
    bus_a.en = 1'b1;
    for (int i = 0; i < 3; i++) step(1);
    bus_a.glyph_sel = 2'd1;
    for (int i = 0; i < 13; i++) step(1);
    bus_a.glyph_sel = 2'd3;
    for (int i = 0; i < 16; i++) step(1);
    bus_a.glyph_sel = 2'd2;
    for (int i = 0; i < 10; i++) step(1);

    // Drop en at row 2, then restart
    bus_a.en = 1'b0; step(1); step(1);
    bus_a.en = 1'b1; for (int i = 0; i < 5; i++) step(1);

    // Asynchronous reset between edges clears the outputs at once
    #2 rst = 1'b1;
    #1;
    chk("async_rst_line", 32'(bus_a.line), 32'h0);
    chk("async_rst_row", 32'(bus_a.row), 32'h0);
    model_reset();
    step(1);
    rst = 1'b0;
    step(1);
    chk("restart_line", 32'(bus_a.line), 32'h01);

    // Blink over six frames of an all-ones glyph
    bus_a.en = 1'b0;
    for (int r = 0; r < RA; r++) wr_a(0, r, 8'hFF);
    bus_a.glyph_sel = 2'd0; bus_a.blink = 1'b1;
    step(1);
    bus_a.en = 1'b1;
    for (int i = 0; i < 6 * RA * DA; i++) step(1);
    bus_a.blink = 1'b0;
    step(1);

    // Randomised stimulus against the model
    for (int i = 0; i < 1200; i++) begin
      rst           = ($urandom_range(0, 199) == 0);
      bus_a.en      = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) bus_a.glyph_sel = 2'($urandom_range(0, 3));
      bus_a.wr_en   = ($urandom_range(0, 2) == 0);
      bus_a.wr_glyph = 2'($urandom_range(0, 3));
      bus_a.wr_row  = 3'($urandom_range(0, 7));
      bus_a.wr_data = 8'($urandom);
      if ($urandom_range(0, 39) == 0) bus_a.blink = ~bus_a.blink;
      step(1);
    end
    rst = 1'b0;
    bus_a.en = 1'b0; bus_a.wr_en = 1'b0;

    // Instance B: dwell 3 over 5 rows, and a write to row 5 is dropped
    bus_b.wr_en = 1'b1; bus_b.wr_glyph = 1'b0;
    bus_b.wr_row = 3'd4; bus_b.wr_data = 4'h9;
    @(posedge fs); #1;
    bus_b.wr_row = 3'd5; bus_b.wr_data = 4'hF;
    @(posedge fs); #1;
    bus_b.wr_row = 3'd7; bus_b.wr_data = 4'hF;
    @(posedge fs); #1;
    bus_b.wr_en = 1'b0; bus_b.en = 1'b1;
    for (int t = 0; t < 3 * RB * DB; t++) begin
      logic [RB-1:0] xl;
      logic [CB-1:0] xr;
      xl = RB'(1) << ((t / DB) % RB);
      xr = (((t / DB) % RB) == 4) ? 4'h9 : 4'h0;
      @(posedge fs); #1;
      chk($sformatf("b_line_t%0d", t), 32'(bus_b.line), 32'(xl));
      chk($sformatf("b_row_t%0d", t), 32'(bus_b.row), 32'(xr));
      chk($sformatf("b_fd_t%0d", t), 32'(bus_b.frame_done),
          32'((t % (RB * DB)) == RB * DB - 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
